// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
//   div_state_t   : control FSM states (idle, iterating, result held)
//   div_cnt_width : width of the iteration counter for a given operand width
package seq_divider_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // Counter must hold the value word_width itself, hence +1.
  function automatic int unsigned div_cnt_width(input int unsigned word_width);
    return $clog2(word_width + 1);
  endfunction

endpackage

// File: rtl/fast_adder.sv
// Grouped carry-lookahead adder.
//   a_i, b_i  : addends (width bits)
//   cin_i     : carry in
//   sum_o     : a_i + b_i + cin_i, truncated to width bits
//   cout_o    : carry out of the top bit
// Bits are split into groups of cascade_size; the last group may be partial.
module fast_adder #(
  parameter int unsigned width        = 17,
  parameter int unsigned cascade_size = 4
) (
  input  logic [width-1:0] a_i,
  input  logic [width-1:0] b_i,
  input  logic             cin_i,
  output logic [width-1:0] sum_o,
  output logic             cout_o
);

  localparam int unsigned NumGroups = (width + cascade_size - 1) / cascade_size;

  always_comb begin
    logic [width-1:0] gen;
    logic [width-1:0] prop;
    logic             grp_carry;
    logic             grp_gen;
    logic             grp_prop;
    logic             bit_carry;
    int               idx;

    gen       = a_i & b_i;
    prop      = a_i ^ b_i;
    sum_o     = '0;
    grp_carry = cin_i;
    grp_gen   = 1'b0;
    grp_prop  = 1'b1;
    bit_carry = 1'b0;
    idx       = 0;

    for (int k = 0; k < int'(NumGroups); k++) begin
      // Group generate/propagate: the inter-group carry skips over the group.
      grp_gen  = 1'b0;
      grp_prop = 1'b1;
      for (int j = 0; j < int'(cascade_size); j++) begin
        idx = k * int'(cascade_size) + j;
        if (idx < int'(width)) begin
          grp_gen  = gen[idx] | (prop[idx] & grp_gen);
          grp_prop = grp_prop & prop[idx];
        end
      end
      // In-group sum bits from the group's incoming carry.
      bit_carry = grp_carry;
      for (int j = 0; j < int'(cascade_size); j++) begin
        idx = k * int'(cascade_size) + j;
        if (idx < int'(width)) begin
          sum_o[idx] = prop[idx] ^ bit_carry;
          bit_carry  = gen[idx] | (prop[idx] & bit_carry);
        end
      end
      grp_carry = grp_gen | (grp_prop & grp_carry);
    end

    cout_o = grp_carry;
  end

endmodule

// File: rtl/fast_comparator.sv
// Unsigned magnitude comparator.
//   a_i, b_i : operands (width bits)
//   ge_o     : 1 when a_i >= b_i
// Scans from the MSB; the first differing bit decides.
module fast_comparator #(
  parameter int unsigned width = 17
) (
  input  logic [width-1:0] a_i,
  input  logic [width-1:0] b_i,
  output logic             ge_o
);

  always_comb begin
    logic decided;
    ge_o    = 1'b1;
    decided = 1'b0;
    for (int i = int'(width) - 1; i >= 0; i--) begin
      if (!decided && (a_i[i] != b_i[i])) begin
        ge_o    = a_i[i];
        decided = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_divider_step.sv
// One combinational restoring-division step.
//   rem_i   : partial remainder R (word_width bits)
//   q_msb_i : next dividend bit shifted into the remainder
//   div_i   : divisor D
//   rem_o   : next partial remainder
//   q_bit_o : quotient bit produced by this step
module seq_divider_step #(
  parameter int unsigned word_width   = 16,
  parameter int unsigned cascade_size = 4
) (
  input  logic [word_width-1:0] rem_i,
  input  logic                  q_msb_i,
  input  logic [word_width-1:0] div_i,
  output logic [word_width-1:0] rem_o,
  output logic                  q_bit_o
);

  localparam int unsigned TrialW = word_width + 1;

  logic [TrialW-1:0] trial;
  logic [TrialW-1:0] div_ext;
  logic [TrialW-1:0] div_inv;
  logic [TrialW-1:0] diff;
  logic              ge;
  logic              unused_carry;
  logic              unused_diff_msb;

  assign trial   = {rem_i, q_msb_i};
  assign div_ext = {1'b0, div_i};
  assign div_inv = ~div_ext;

  fast_comparator #(
    .width(TrialW)
  ) u_cmp (
    .a_i (trial),
    .b_i (div_ext),
    .ge_o(ge)
  );

  // trial - D as trial + ~D + 1; the comparator, not the carry, picks the result.
  fast_adder #(
    .width       (TrialW),
    .cascade_size(cascade_size)
  ) u_sub (
    .a_i   (trial),
    .b_i   (div_inv),
    .cin_i (1'b1),
    .sum_o (diff),
    .cout_o(unused_carry)
  );

  // When trial >= D the difference is < D, so its top bit is always zero.
  assign unused_diff_msb = diff[TrialW-1];

  assign rem_o   = ge ? diff[word_width-1:0] : trial[word_width-1:0];
  assign q_bit_o = ge;

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
//   clk, reset           : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (dividend, divisor)
//   out_valid / out_ready: result handshake (quotient, remainder, div_by_zero)
// A zero divisor skips iteration: quotient all ones, remainder = dividend.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned word_width   = 16,
  parameter int unsigned cascade_size = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [word_width-1:0] dividend,
  input  logic [word_width-1:0] divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [word_width-1:0] quotient,
  output logic [word_width-1:0] remainder,
  output logic                  div_by_zero
);

  localparam int unsigned CntW = div_cnt_width(word_width);

  div_state_t            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [word_width-1:0] rem_q, rem_d;
  logic [word_width-1:0] quo_q, quo_d;
  logic [word_width-1:0] div_q, div_d;
  logic [word_width-1:0] quotient_q, quotient_d;
  logic [word_width-1:0] remainder_q, remainder_d;
  logic                  dbz_q, dbz_d;

  logic [word_width-1:0] step_rem;
  logic                  step_bit;
  logic [word_width-1:0] quo_shifted;

  seq_divider_step #(
    .word_width  (word_width),
    .cascade_size(cascade_size)
  ) u_step (
    .rem_i  (rem_q),
    .q_msb_i(quo_q[word_width-1]),
    .div_i  (div_q),
    .rem_o  (step_rem),
    .q_bit_o(step_bit)
  );

  // Q doubles as the dividend shift register: its MSB feeds R, quotient bits enter at the LSB.
  assign quo_shifted = {quo_q[word_width-2:0], step_bit};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    div_d       = div_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    unique case (state_q)
      DIV_IDLE: begin
        if (in_valid) begin
          quo_d = dividend;
          div_d = divisor;
          rem_d = '0;
          cnt_d = CntW'(word_width);
          if (divisor == '0) begin
            state_d     = DIV_DONE;
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = DIV_RUN;
          end
        end
      end
      DIV_RUN: begin
        rem_d = step_rem;
        quo_d = quo_shifted;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d     = DIV_DONE;
          quotient_d  = quo_shifted;
          remainder_d = step_rem;
          dbz_d       = 1'b0;
        end
      end
      DIV_DONE: begin
        if (out_ready) begin
          state_d = DIV_IDLE;
        end
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= DIV_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      div_q       <= div_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign in_ready    = (state_q == DIV_IDLE);
  assign out_valid   = (state_q == DIV_DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed table (16-bit), stall, mid-run reset,
// then random back-to-back traffic on a 16-bit and an 8-bit instance in parallel.
module tb_seq_divider;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // 16-bit instance
  logic        iv16 = 1'b0, ir16, ov16, or16 = 1'b0, dz16;
  logic [15:0] a16 = '0, b16 = '0, q16, r16;
  // 8-bit instance
  logic        iv8 = 1'b0, ir8, ov8, or8 = 1'b0, dz8;
  logic [7:0]  a8 = '0, b8 = '0, q8, r8;

  seq_divider #(.word_width(16), .cascade_size(4)) dut16 (
    .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16), .dividend(a16),
    .divisor(b16), .out_valid(ov16), .out_ready(or16), .quotient(q16),
    .remainder(r16), .div_by_zero(dz16)
  );

  seq_divider #(.word_width(8), .cascade_size(2)) dut8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8), .dividend(a8),
    .divisor(b8), .out_valid(ov8), .out_ready(or8), .quotient(q8),
    .remainder(r8), .div_by_zero(dz8)
  );

  int checks = 0;
  int errors = 0;
  vec_t sb16[$];
  vec_t sb8[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [15:0] a, input logic [15:0] b,
                                 input int unsigned w);
    vec_t v;
    logic [15:0] ones;
    ones  = (w == 8) ? 16'h00ff : 16'hffff;
    v.a   = a;
    v.b   = b;
    if (b == 0) begin
      v.q = ones; v.r = a; v.dbz = 1'b1;
    end else begin
      v.q = a / b; v.r = a % b; v.dbz = 1'b0;
    end
    return v;
  endfunction

  // One full transaction on dut16 with latency and result checks.
  task automatic run_vec(input vec_t v);
    vec_t e;
    int n;
    @(negedge clk);
    iv16 = 1'b1; a16 = v.a; b16 = v.b; or16 = 1'b0;
    n = 0;
    while (!ir16 && n < 50) begin @(negedge clk); n++; end
    check("accept_ready", ir16, 1);
    sb16.push_back(v);
    @(negedge clk);
    iv16 = 1'b0;
    n = 0;
    while (!ov16 && n < 40) begin @(negedge clk); n++; end
    check("latency", n, (v.b == 0) ? 0 : 16);
    e = sb16.pop_front();
    check("quotient", q16, e.q);
    check("remainder", r16, e.r);
    check("div_by_zero", dz16, e.dbz);
    check("in_ready_done", ir16, 0);
    or16 = 1'b1;
    @(negedge clk);
    or16 = 1'b0;
    check("out_valid_clear", ov16, 0);
    check("in_ready_idle", ir16, 1);
  endtask

  task automatic drive_rand16();
    logic [15:0] a, b;
    int n;
    for (int i = 0; i < 200; i++) begin
      a = 16'($urandom);
      b = ($urandom_range(0, 19) == 0) ? 16'h0 :
          ($urandom_range(0, 1) == 0) ? 16'($urandom_range(1, 300)) : 16'($urandom);
      @(negedge clk);
      iv16 = 1'b1; a16 = a; b16 = b;
      n = 0;
      while (!ir16 && n < 50) begin @(negedge clk); n++; end
      if (!ir16) begin
        check("rand16_accept_timeout", 0, 1);
        break;
      end
      sb16.push_back(model(a, b, 16));
    end
    @(negedge clk);
    iv16 = 1'b0;
  endtask

  task automatic mon_rand16();
    vec_t e;
    int got, n;
    got = 0; n = 0;
    or16 = 1'b1;
    while (got < 200 && n < 5000) begin
      @(negedge clk);
      n++;
      if (ov16) begin
        if (sb16.size() == 0) begin
          check("rand16_unexpected_result", 1, 0);
        end else begin
          e = sb16.pop_front();
          check("rand16_q", q16, e.q);
          check("rand16_r", r16, e.r);
          check("rand16_dbz", dz16, e.dbz);
          if (e.b != 0)
            check("rand16_invariant",
                  ((32'(q16) * 32'(e.b) + 32'(r16)) == 32'(e.a)) && (r16 < e.b), 1);
        end
        got++;
      end
    end
    check("rand16_count", got, 200);
    or16 = 1'b0;
  endtask

  task automatic drive_rand8();
    logic [7:0] a, b;
    int n;
    for (int i = 0; i < 200; i++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 19) == 0) ? 8'h0 : 8'($urandom_range(1, 255));
      @(negedge clk);
      iv8 = 1'b1; a8 = a; b8 = b;
      n = 0;
      while (!ir8 && n < 50) begin @(negedge clk); n++; end
      if (!ir8) begin
        check("rand8_accept_timeout", 0, 1);
        break;
      end
      sb8.push_back(model({8'h0, a}, {8'h0, b}, 8));
    end
    @(negedge clk);
    iv8 = 1'b0;
  endtask

  task automatic mon_rand8();
    vec_t e;
    int got, n;
    got = 0; n = 0;
    or8 = 1'b1;
    while (got < 200 && n < 5000) begin
      @(negedge clk);
      n++;
      if (ov8) begin
        if (sb8.size() == 0) begin
          check("rand8_unexpected_result", 1, 0);
        end else begin
          e = sb8.pop_front();
          check("rand8_q", {8'h0, q8}, e.q);
          check("rand8_r", {8'h0, r8}, e.r);
          check("rand8_dbz", dz8, e.dbz);
          if (e.b != 0)
            check("rand8_invariant",
                  ((32'(q8) * 32'(e.b) + 32'(r8)) == 32'(e.a)) && (16'(r8) < e.b), 1);
        end
        got++;
      end
    end
    check("rand8_count", got, 200);
    or8 = 1'b0;
  endtask

  vec_t table_v[8];

  initial begin
    table_v[0] = '{a: 16'd100,   b: 16'd7,      q: 16'd14,    r: 16'd2,    dbz: 1'b0};
    table_v[1] = '{a: 16'd1234,  b: 16'd0,      q: 16'hffff,  r: 16'd1234, dbz: 1'b1};
    table_v[2] = '{a: 16'hffff,  b: 16'd1,      q: 16'hffff,  r: 16'd0,    dbz: 1'b0};
    table_v[3] = '{a: 16'd5,     b: 16'd9,      q: 16'd0,     r: 16'd5,    dbz: 1'b0};
    table_v[4] = '{a: 16'd0,     b: 16'd5,      q: 16'd0,     r: 16'd0,    dbz: 1'b0};
    table_v[5] = '{a: 16'hffff,  b: 16'hffff,   q: 16'd1,     r: 16'd0,    dbz: 1'b0};
    table_v[6] = '{a: 16'd50000, b: 16'd3,      q: 16'd16666, r: 16'd2,    dbz: 1'b0};
    table_v[7] = '{a: 16'd40000, b: 16'h8000,   q: 16'd1,     r: 16'd7232, dbz: 1'b0};

    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_in_ready", ir16, 1);
    check("reset_out_valid", ov16, 0);
    check("reset_quotient", q16, 0);
    check("reset_remainder", r16, 0);
    check("reset_dbz", dz16, 0);
    check("reset8_in_ready", ir8, 1);

    for (int i = 0; i < 8; i++) run_vec(table_v[i]);

    // Stall in DONE: outputs must hold for 10 cycles with out_ready low.
    begin
      int n;
      @(negedge clk);
      iv16 = 1'b1; a16 = 16'd100; b16 = 16'd7; or16 = 1'b0;
      @(negedge clk);
      iv16 = 1'b0;
      n = 0;
      while (!ov16 && n < 40) begin @(negedge clk); n++; end
      check("stall_latency", n, 16);
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        check("stall_out_valid", ov16, 1);
        check("stall_q", q16, 14);
        check("stall_r", r16, 2);
        check("stall_in_ready", ir16, 0);
      end
      or16 = 1'b1;
      @(negedge clk);
      or16 = 1'b0;
      check("stall_release_ov", ov16, 0);
      check("stall_release_ir", ir16, 1);
      check("stall_keep_q", q16, 14);
    end

    // Reset in the middle of an iteration abandons the operation.
    @(negedge clk);
    iv16 = 1'b1; a16 = 16'd1000; b16 = 16'd3;
    @(negedge clk);
    iv16 = 1'b0;
    repeat (7) @(negedge clk);
    check("midrun_busy", ir16, 0);
    reset = 1'b1;
    @(negedge clk);
    check("midrun_reset_ir", ir16, 1);
    check("midrun_reset_ov", ov16, 0);
    check("midrun_reset_q", q16, 0);
    reset = 1'b0;
    repeat (20) begin
      @(negedge clk);
      check("midrun_no_result", ov16, 0);
    end
    run_vec('{a: 16'd50, b: 16'd5, q: 16'd10, r: 16'd0, dbz: 1'b0});

    fork
      drive_rand16();
      mon_rand16();
      drive_rand8();
      mon_rand8();
    join

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
